pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl_pkg.sv | 20 ++
 rtl/pipe_ctrl_if.sv | 38 +++
 rtl/pipe_ctrl_div_watchdog.sv | 31 +++
 rtl/pipe_ctrl.sv | 139 +++++++++++++
 tb/tb_pipe_ctrl.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline hazard controller:
// stall vector encodings and FSM state encoding.
package pipe_ctrl_pkg;

    localparam int STALL_W = 6;

    typedef logic [STALL_W-1:0] stall_t;

    localparam stall_t STALL_NONE = 6'b000000;
    localparam stall_t STALL_ID   = 6'b000111;
    localparam stall_t STALL_EX   = 6'b001111;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DIV_WAIT = 2'd1,
        ST_DIV_DONE = 2'd2,
        ST_FLUSH    = 2'd3
    } state_t;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Hazard request / pipeline control bundle between
// the pipeline stages (master) and pipe_ctrl (slave).
interface pipe_ctrl_if
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W = 16
) ();

    logic             id_stallreq;
    logic             ex_div_req;
    logic             div_ready_i;
    logic             flush_req;
    logic             cnt_clr;
    stall_t           stall_o;
    logic             flush_o;
    logic             div_start_o;
    logic             div_annul_o;
    logic             timeout_o;
    logic             busy_o;
    logic [CNT_W-1:0] stall_cnt_o;

    modport master (
        output id_stallreq, ex_div_req, div_ready_i,
        output flush_req, cnt_clr,
        input  stall_o, flush_o, div_start_o,
        input  div_annul_o, timeout_o, busy_o,
        input  stall_cnt_o
    );

    modport slave (
        input  id_stallreq, ex_div_req, div_ready_i,
        input  flush_req, cnt_clr,
        output stall_o, flush_o, div_start_o,
        output div_annul_o, timeout_o, busy_o,
        output stall_cnt_o
    );

endinterface

// File: rtl/pipe_ctrl_div_watchdog.sv
// Divider watchdog: counts cycles while enabled and
// pulses expire on the DIV_TIMEOUT-th enabled cycle.
module div_watchdog #(
    parameter int DIV_TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int W = (DIV_TIMEOUT > 1) ? $clog2(DIV_TIMEOUT) : 1;
    localparam logic [W-1:0] LAST = W'(DIV_TIMEOUT - 1);

    logic [W-1:0] count;

    assign expire = enable && (count == LAST);

    // cycle counter, held at LAST so it never wraps
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expire) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: load-use stalls, multi-cycle
// divide stalls with watchdog, flush sequencing, stall counter.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int DIV_TIMEOUT = 64,
    parameter int CNT_W       = 16
) (
    input logic        clk,
    input logic        rst,
    pipe_ctrl_if.slave bus
);

    state_t           state;
    state_t           next;
    stall_t           stall;
    logic             flush;
    logic             start;
    logic             annul;
    logic             tout;
    logic             busy;
    logic             expire;
    logic             wd_en;
    logic [CNT_W-1:0] cnt;

    assign wd_en = (state == ST_DIV_WAIT);

    div_watchdog #(
        .DIV_TIMEOUT(DIV_TIMEOUT)
    ) u_wd (
        .clk   (clk),
        .rst   (rst),
        .clear (start),
        .enable(wd_en),
        .expire(expire)
    );

    // state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next;
        end
    end

    // next-state: flush wins, then divider events
    always_comb begin
        next = state;
        unique case (state)
            ST_IDLE: begin
                if (bus.flush_req) begin
                    next = ST_FLUSH;
                end else if (bus.ex_div_req) begin
                    next = ST_DIV_WAIT;
                end
            end
            ST_DIV_WAIT: begin
                if (bus.flush_req) begin
                    next = ST_FLUSH;
                end else if (bus.div_ready_i) begin
                    next = ST_DIV_DONE;
                end else if (expire) begin
                    next = ST_IDLE;
                end
            end
            ST_DIV_DONE: begin
                next = bus.flush_req ? ST_FLUSH : ST_IDLE;
            end
            ST_FLUSH: begin
                next = ST_IDLE;
            end
            default: begin
                next = ST_IDLE;
            end
        endcase
    end

    // outputs, all forced low while reset is held
    always_comb begin
        stall = STALL_NONE;
        flush = 1'b0;
        start = 1'b0;
        annul = 1'b0;
        tout  = 1'b0;
        busy  = 1'b0;
        if (rst) begin
            busy = (state != ST_IDLE);
            unique case (state)
                ST_IDLE: begin
                    if (bus.ex_div_req && !bus.flush_req) begin
                        stall = STALL_EX;
                        start = 1'b1;
                    end else if (bus.id_stallreq) begin
                        stall = STALL_ID;
                    end
                end
                ST_DIV_WAIT: begin
                    stall = STALL_EX;
                    if (bus.flush_req) begin
                        annul = 1'b1;
                    end else if (!bus.div_ready_i && expire) begin
                        annul = 1'b1;
                        tout  = 1'b1;
                    end
                end
                ST_DIV_DONE: begin
                    stall = STALL_NONE;
                end
                ST_FLUSH: begin
                    flush = 1'b1;
                end
                default: begin
                    stall = STALL_NONE;
                end
            endcase
        end
    end

    // saturating count of cycles with the pc held
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (bus.cnt_clr) begin
            cnt <= '0;
        end else if (stall[0] && (cnt != '1)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign bus.stall_o     = stall;
    assign bus.flush_o     = flush;
    assign bus.div_start_o = start;
    assign bus.div_annul_o = annul;
    assign bus.timeout_o   = tout;
    assign bus.busy_o      = busy;
    assign bus.stall_cnt_o = cnt;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: IDLE decode table plus
// hand-built divide, flush, timeout, counter and reset sequences.
module tb_pipe_ctrl;
    import pipe_ctrl_pkg::*;

    localparam int CNT_W = 4;
    localparam int TO    = 8;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    pipe_ctrl_if #(.CNT_W(CNT_W)) bus ();

    pipe_ctrl #(
        .DIV_TIMEOUT(TO),
        .CNT_W      (CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int errs   = 0;
    int checks = 0;

    typedef struct {
        logic       id;
        logic       ex;
        logic       rdy;
        logic       fl;
        logic [5:0] st;
        logic       start;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [5:0] st,
                           input logic fo, input logic ds,
                           input logic da, input logic to,
                           input logic bz);
        chk({tag, ".stall"}, 32'(bus.stall_o), 32'(st));
        chk({tag, ".flush"}, 32'(bus.flush_o), 32'(fo));
        chk({tag, ".start"}, 32'(bus.div_start_o), 32'(ds));
        chk({tag, ".annul"}, 32'(bus.div_annul_o), 32'(da));
        chk({tag, ".timeout"}, 32'(bus.timeout_o), 32'(to));
        chk({tag, ".busy"}, 32'(bus.busy_o), 32'(bz));
    endtask

    task automatic set_in(input logic id, input logic ex,
                          input logic rdy, input logic fl,
                          input logic clr);
        bus.id_stallreq = id;
        bus.ex_div_req  = ex;
        bus.div_ready_i = rdy;
        bus.flush_req   = fl;
        bus.cnt_clr     = clr;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 6'b000000, 1'b0};
        tbl[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 6'b000111, 1'b0};
        tbl[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 6'b001111, 1'b1};
        tbl[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 6'b001111, 1'b1};
        tbl[4] = '{1'b0, 1'b0, 1'b0, 1'b1, 6'b000000, 1'b0};
        tbl[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 6'b001111, 1'b1};
        tbl[6] = '{1'b0, 1'b1, 1'b0, 1'b1, 6'b000000, 1'b0};
        tbl[7] = '{1'b0, 1'b0, 1'b1, 1'b0, 6'b000000, 1'b0};

        // reset held with requests active: all outputs low
        rst = 1'b0;
        set_in(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        chk_out("rst", 6'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("rst.cnt", 32'(bus.stall_cnt_o), 32'd0);
        tick();
        rst = 1'b1;
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("rel.busy", 32'(bus.busy_o), 32'd0);
        tick();

        // load-use for two cycles
        for (int c = 0; c < 2; c++) begin
            set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            #1;
            chk_out("lu", 6'b000111, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            tick();
        end
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("lu.cnt", 32'(bus.stall_cnt_o), 32'd2);
        tick();

        // IDLE decode table; inputs dropped before each edge
        for (int i = 0; i < 8; i++) begin
            set_in(tbl[i].id, tbl[i].ex, tbl[i].rdy, tbl[i].fl, 1'b0);
            #1;
            chk_out($sformatf("tbl%0d", i), tbl[i].st, 1'b0,
                    tbl[i].start, 1'b0, 1'b0, 1'b0);
            set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            tick();
        end

        // divide: issue at cycle 0, ready at cycle 5
        set_in(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        chk_out("div0", 6'b001111, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        for (int c = 1; c < 6; c++) begin
            set_in(1'b0, 1'b1, (c == 5), 1'b0, 1'b0);
            #1;
            chk_out($sformatf("div%0d", c), 6'b001111, 1'b0,
                    1'b0, 1'b0, 1'b0, 1'b1);
            tick();
        end
        set_in(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        chk_out("div6", 6'b000000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        chk_out("div7", 6'b000000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("div7.cnt", 32'(bus.stall_cnt_o), 32'd8);
        tick();

        // flush arriving at cycle 3 of a divide
        set_in(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        tick();
        set_in(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        #1;
        chk_out("fd3", 6'b001111, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        tick();
        set_in(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        #1;
        chk_out("fd4", 6'b000000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        chk_out("fd5", 6'b000000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();

        // watchdog expiry after TO cycles in DIV_WAIT
        set_in(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        for (int c = 1; c < TO; c++) begin
            #1;
            chk(($sformatf("to%0d.annul", c)),
                32'(bus.div_annul_o), 32'd0);
            chk(($sformatf("to%0d.timeout", c)),
                32'(bus.timeout_o), 32'd0);
            tick();
        end
        #1;
        chk_out("to8", 6'b001111, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        tick();
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        chk_out("to9", 6'b000000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();

        // flush, divide and load-use all at once in IDLE
        set_in(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        #1;
        chk("sim.start", 32'(bus.div_start_o), 32'd0);
        chk("sim.flush", 32'(bus.flush_o), 32'd0);
        tick();
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        chk_out("sim1", 6'b000000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        #1;
        chk("sim2.busy", 32'(bus.busy_o), 32'd0);

        // counter clear, saturation, clear beating a stall
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("clr.cnt", 32'(bus.stall_cnt_o), 32'd0);
        set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int c = 0; c < (1 << CNT_W) + 3; c++) begin
            tick();
        end
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("sat.cnt", 32'(bus.stall_cnt_o), 32'd15);
        set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("clrst.cnt", 32'(bus.stall_cnt_o), 32'd0);
        set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("inc.cnt", 32'(bus.stall_cnt_o), 32'd1);
        tick();

        // reset mid-divide with a flush pending: no annul
        set_in(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        set_in(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        #1;
        rst = 1'b0;
        #1;
        chk_out("rmid", 6'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("rmid.cnt", 32'(bus.stall_cnt_o), 32'd0);
        tick();
        #1;
        chk_out("rhold", 6'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        set_in(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        chk_out("rrel", 6'b001111, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        set_in(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        #1;
        chk_out("rwait", 6'b001111, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        #1;
        chk("rend.busy", 32'(bus.busy_o), 32'd0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
